store_buffer: RTL and testbench

- Posted-write FIFO between the MEM pipeline stage and the data memory.
- Accepts word stores from the pipeline in a single cycle and drains them to the memory write port one per cycle whenever that port is free.
- Lets the pipeline continue without waiting for memory.
- Forwards buffered data to younger loads so that read-after-write ordering holds.

---
 rtl/store_buffer.sv | 122 ++++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write FIFO between the MEM stage and the data memory. Word stores
//   are accepted in one cycle. They are drained to the memory write port one
//   per cycle whenever that port is not taken by a load. Loads that hit a
//   buffered word get its youngest copy forwarded.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stValid/stAdr/stData/stReady
//                     store request from the pipeline (word granular)
//   ldAdr/ldHit/ldData
//                     combinational load lookup against buffered stores
//   memBusy           memory port taken by a load this cycle (blocks drain)
//   memAdr/writeData/memWrite
//                     drain port to data memory (head entry)
//   empty             no pending stores (fence / halt)
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stValid,
  input  logic [ADDR_W-1:0] stAdr,
  input  logic [DATA_W-1:0] stData,
  output logic              stReady,
  input  logic [ADDR_W-1:0] ldAdr,
  output logic              ldHit,
  output logic [DATA_W-1:0] ldData,
  input  logic              memBusy,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] writeData,
  output logic              memWrite,
  output logic              empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WADR_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage stays in registers: forwarding reads every entry at once.
  logic [WADR_W-1:0] adrArr  [DEPTH];
  logic [DATA_W-1:0] dataArr [DEPTH];

  logic [PTR_W-1:0] headReg;
  logic [PTR_W-1:0] tailReg;
  logic [CNT_W-1:0] countReg;

  logic             push;
  logic             drain;
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] ageIdx [DEPTH];

  // Byte-lane bits of the addresses are intentionally ignored.
  logic unusedBits;
  assign unusedBits = ^{stAdr[1:0], ldAdr[1:0]};

  // stReady looks only at count, so a full buffer refuses a store even in a
  // cycle where it drains.
  assign stReady   = (countReg != FULL_CNT);
  assign empty     = (countReg == '0);
  assign memWrite  = !empty && !memBusy;
  assign push      = stValid && stReady;
  assign drain     = memWrite;
  assign memAdr    = {adrArr[headReg], 2'b00};
  assign writeData = dataArr[headReg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic [PTR_W-1:0] age;
      // Distance from head. An entry is occupied when this is below count.
      // Wraps naturally because DEPTH is a power of two.
      assign age         = PTR_W'(gi) - headReg;
      assign match[gi]   = ({1'b0, age} < countReg) &&
                           (adrArr[gi] == ldAdr[ADDR_W-1:2]);
      // Physical index of the gi-th oldest entry.
      assign ageIdx[gi]  = headReg + PTR_W'(gi);
    end
  endgenerate

  // Walk from oldest to youngest so that the last match wins.
  always_comb begin
    ldHit  = |match;
    ldData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[ageIdx[k]]) begin
        ldData = dataArr[ageIdx[k]];
      end
    end
  end

  // Entry payload. It needs no reset because occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      adrArr[tailReg]  <= stAdr[ADDR_W-1:2];
      dataArr[tailReg] <= stData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
    end else begin
      if (push) begin
        tailReg <= tailReg + PTR_W'(1);
      end
      if (drain) begin
        headReg <= headReg + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed self-checking bench for store_buffer (DEPTH=4, 32-bit address
//   and data). Inputs change 1 time unit after a rising edge. Outputs are
//   checked 1 time unit later, well before the next edge.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stValid;
  logic [31:0] stAdr;
  logic [31:0] stData;
  logic        stReady;
  logic [31:0] ldAdr;
  logic        ldHit;
  logic [31:0] ldData;
  logic        memBusy;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic        memWrite;
  logic        empty;

  int passCnt  = 0;
  int checkCnt = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .stValid   (stValid),
    .stAdr     (stAdr),
    .stData    (stData),
    .stReady   (stReady),
    .ldAdr     (ldAdr),
    .ldHit     (ldHit),
    .ldData    (ldData),
    .memBusy   (memBusy),
    .memAdr    (memAdr),
    .writeData (writeData),
    .memWrite  (memWrite),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Move to the next cycle's drive point.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic busy);
    stValid = v;
    stAdr   = a;
    stData  = d;
    memBusy = busy;
    #1;
  endtask

  initial begin
    rst = 1'b1; stValid = 1'b0; stAdr = '0; stData = '0; ldAdr = '0; memBusy = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_stReady", 32'(stReady), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_ldHit", 32'(ldHit), 32'd0);
    nextCycle();

    // 1: single store, one-cycle latency to drain
    drive(1'b1, 32'h100, 32'hAAAA0001, 1'b0);
    check("t1_c0_memWrite", 32'(memWrite), 32'd0);
    check("t1_c0_empty", 32'(empty), 32'd1);
    nextCycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    ldAdr = 32'h100;
    #1;
    check("t1_c1_memWrite", 32'(memWrite), 32'd1);
    check("t1_c1_memAdr", memAdr, 32'h100);
    check("t1_c1_writeData", writeData, 32'hAAAA0001);
    check("t1_c1_empty", 32'(empty), 32'd0);
    check("t1_c1_fwdHit", 32'(ldHit), 32'd1);
    check("t1_c1_fwdData", ldData, 32'hAAAA0001);
    nextCycle();
    check("t1_c2_empty", 32'(empty), 32'd1);
    check("t1_c2_memWrite", 32'(memWrite), 32'd0);

    // 2: fill while memBusy, reject a 5th store, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1);
      check($sformatf("t2_push%0d_stReady", i), 32'(stReady), 32'd1);
      check($sformatf("t2_push%0d_memWrite", i), 32'(memWrite), 32'd0);
      nextCycle();
    end
    drive(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1);
    check("t2_full_stReady", 32'(stReady), 32'd0);
    nextCycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain%0d_memWrite", i), 32'(memWrite), 32'd1);
      check($sformatf("t2_drain%0d_memAdr", i), memAdr, 32'h10 + 32'(4 * i));
      check($sformatf("t2_drain%0d_writeData", i), writeData, 32'hB000_0000 + 32'(i));
      nextCycle();
    end
    check("t2_end_empty", 32'(empty), 32'd1);
    check("t2_end_memWrite", 32'(memWrite), 32'd0);

    // 3: forwarding picks the youngest match and ignores the store being pushed
    drive(1'b1, 32'h40, 32'h11, 1'b1);
    nextCycle();
    ldAdr = 32'h40;
    drive(1'b1, 32'h40, 32'h22, 1'b1);
    check("t3_samecycle_ldData", ldData, 32'h11);
    nextCycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    ldAdr = 32'h42;
    #1;
    check("t3_hit_42", 32'(ldHit), 32'd1);
    check("t3_data_42", ldData, 32'h22);
    ldAdr = 32'h44;
    #1;
    check("t3_hit_44", 32'(ldHit), 32'd0);
    nextCycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t3_drain0_memAdr", memAdr, 32'h40);
    check("t3_drain0_writeData", writeData, 32'h11);
    nextCycle();
    check("t3_drain1_memAdr", memAdr, 32'h40);
    check("t3_drain1_writeData", writeData, 32'h22);
    nextCycle();
    check("t3_end_empty", 32'(empty), 32'd1);

    // 4: a full buffer draining in the same cycle still refuses the store
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1);
      nextCycle();
    end
    drive(1'b1, 32'h90, 32'hC4, 1'b0);
    check("t4_full_stReady", 32'(stReady), 32'd0);
    check("t4_full_memWrite", 32'(memWrite), 32'd1);
    check("t4_full_memAdr", memAdr, 32'h80);
    nextCycle();
    #1;
    check("t4_retry_stReady", 32'(stReady), 32'd1);
    check("t4_retry_memAdr", memAdr, 32'h84);
    nextCycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t4_d2_memAdr", memAdr, 32'h88);
    nextCycle();
    check("t4_d3_memAdr", memAdr, 32'h8C);
    nextCycle();
    check("t4_d4_memAdr", memAdr, 32'h90);
    check("t4_d4_writeData", writeData, 32'hC4);
    check("t4_d4_memWrite", 32'(memWrite), 32'd1);
    nextCycle();
    check("t4_end_empty", 32'(empty), 32'd1);

    // 5: streaming push every cycle; pointers wrap, drains follow one behind
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 32'(k), 1'b0);
      check($sformatf("t5_c%0d_stReady", k), 32'(stReady), 32'd1);
      if (k == 0) begin
        check("t5_c0_memWrite", 32'(memWrite), 32'd0);
      end else begin
        check($sformatf("t5_c%0d_memWrite", k), 32'(memWrite), 32'd1);
        check($sformatf("t5_c%0d_memAdr", k), memAdr, 32'h200 + 32'(4 * (k - 1)));
        check($sformatf("t5_c%0d_writeData", k), writeData, 32'(k - 1));
      end
      nextCycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t5_last_memWrite", 32'(memWrite), 32'd1);
    check("t5_last_memAdr", memAdr, 32'h224);
    check("t5_last_writeData", writeData, 32'd9);
    nextCycle();
    check("t5_end_empty", 32'(empty), 32'd1);

    // 6: reset discards pending stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hE0 + 32'(i), 1'b1);
      nextCycle();
    end
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t6_rstcycle_memWrite", 32'(memWrite), 32'd1);
    nextCycle();
    rst = 1'b0;
    #1;
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_memWrite", 32'(memWrite), 32'd0);
    check("t6_stReady", 32'(stReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ldAdr = 32'h300 + 32'(4 * i);
      #1;
      check($sformatf("t6_ldHit%0d", i), 32'(ldHit), 32'd0);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
